debug_unit: RTL and testbench

Host-side controller for the MIPS pipeline's debug port. It turns a byte stream from the UART receiver into program-load, run, step and PC-reset operations on the pipeline. After each run or step it reads back the register file and data memory and sends them to the UART transmitter. It drives every `dunit` input of the pipeline and consumes its `dunit` outputs and halt flag.

---
 rtl/debug_unit.sv | 216 +++++++++++++++++++++
 tb/tb_debug_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// debug_unit : UART-byte-driven load / run / step / PC-reset controller for
//              the MIPS pipeline debug port, with register and memory dump.
// Revision   : 1.0  initial release
// ============================================================================
module debug_unit #(
   parameter int NB_REG      = 32,
   parameter int NB_DATA     = 8,
   parameter int N_REGS      = 32,
   parameter int N_MEM_WORDS = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_dunit_clk_en,
   output logic               o_dunit_reset_pc,
   output logic               o_dunit_w_mem,
   output logic [NB_REG-1:0]  o_dunit_addr,
   output logic [NB_REG-1:0]  o_dunit_data_if,
   input  logic [NB_REG-1:0]  i_dunit_reg,
   input  logic [NB_REG-1:0]  i_dunit_mem_data,
   input  logic               i_halt
);

   localparam int N_DUMP = N_REGS + N_MEM_WORDS;
   localparam int IDX_W  = $clog2(N_DUMP + 1);

   localparam logic [NB_DATA-1:0] CMD_LOAD  = NB_DATA'(8'h4C);
   localparam logic [NB_DATA-1:0] CMD_RUN   = NB_DATA'(8'h43);
   localparam logic [NB_DATA-1:0] CMD_STEP  = NB_DATA'(8'h53);
   localparam logic [NB_DATA-1:0] CMD_RESET = NB_DATA'(8'h52);

   localparam logic [1:0]       LAST_BYTE = 2'(NB_REG / NB_DATA - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DUMP - 1);
   localparam logic [IDX_W-1:0] REGS_IDX  = IDX_W'(N_REGS);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      LOAD_CNT    = 4'd1,
      LOAD_BYTE   = 4'd2,
      LOAD_WRITE  = 4'd3,
      RUN         = 4'd4,
      STEP        = 4'd5,
      DUMP_ADDR   = 4'd6,
      DUMP_SAMPLE = 4'd7,
      DUMP_TX     = 4'd8,
      DUMP_WAIT   = 4'd9
   } state_t;

   state_t            state_q,    state_d;
   logic [8:0]        wcnt_q,     wcnt_d;
   logic [8:0]        widx_q,     widx_d;
   logic [1:0]        byte_q,     byte_d;
   logic [IDX_W-1:0]  didx_q,     didx_d;
   logic [NB_REG-1:0] addr_q,     addr_d;
   logic [NB_REG-1:0] data_if_q,  data_if_d;
   logic [NB_REG-1:0] tx_word_q,  tx_word_d;
   logic              reset_pc_q, reset_pc_d;

   logic              clk_en;
   logic              w_mem;
   logic              tx_start;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         widx_q     <= '0;
         byte_q     <= '0;
         didx_q     <= '0;
         addr_q     <= '0;
         data_if_q  <= '0;
         tx_word_q  <= '0;
         reset_pc_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         widx_q     <= widx_d;
         byte_q     <= byte_d;
         didx_q     <= didx_d;
         addr_q     <= addr_d;
         data_if_q  <= data_if_d;
         tx_word_q  <= tx_word_d;
         reset_pc_q <= reset_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      widx_d     = widx_q;
      byte_d     = byte_q;
      didx_d     = didx_q;
      addr_d     = addr_q;
      data_if_d  = data_if_q;
      tx_word_d  = tx_word_q;
      reset_pc_d = 1'b0;
      clk_en     = 1'b0;
      w_mem      = 1'b0;
      tx_start   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_rx_done) begin
               case (i_rx_data)
                  CMD_LOAD:  state_d = LOAD_CNT;
                  CMD_RUN:   state_d = i_halt ? DUMP_ADDR : RUN;
                  CMD_STEP:  state_d = i_halt ? DUMP_ADDR : STEP;
                  CMD_RESET: reset_pc_d = 1'b1;
                  default:   state_d = IDLE;
               endcase
            end
         end

         LOAD_CNT: begin
            if (i_rx_done) begin
               // A count byte of zero stands for the full 256-word load.
               wcnt_d  = (i_rx_data == '0) ? 9'd256 : 9'(i_rx_data);
               widx_d  = '0;
               byte_d  = '0;
               state_d = LOAD_BYTE;
            end
         end

         LOAD_BYTE: begin
            if (i_rx_done) begin
               data_if_d = {data_if_q[NB_REG-NB_DATA-1:0], i_rx_data};
               byte_d    = byte_q + 2'd1;
               if (byte_q == LAST_BYTE) begin
                  addr_d  = NB_REG'(widx_q) << 2;
                  state_d = LOAD_WRITE;
               end
            end
         end

         LOAD_WRITE: begin
            w_mem  = 1'b1;
            widx_d = widx_q + 9'd1;
            if (widx_q + 9'd1 == wcnt_q) begin
               reset_pc_d = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = LOAD_BYTE;
            end
         end

         RUN: begin
            // Enable is withdrawn in the very cycle halt is observed.
            if (i_halt) begin
               state_d = DUMP_ADDR;
            end else begin
               clk_en = 1'b1;
            end
         end

         STEP: begin
            clk_en  = 1'b1;
            state_d = DUMP_ADDR;
         end

         DUMP_ADDR: begin
            if (didx_q < REGS_IDX) begin
               addr_d = NB_REG'(didx_q);
            end else begin
               addr_d = NB_REG'(didx_q - REGS_IDX) << 2;
            end
            state_d = DUMP_SAMPLE;
         end

         DUMP_SAMPLE: begin
            tx_word_d = (didx_q < REGS_IDX) ? i_dunit_reg : i_dunit_mem_data;
            byte_d    = '0;
            state_d   = DUMP_TX;
         end

         DUMP_TX: begin
            tx_start = 1'b1;
            state_d  = DUMP_WAIT;
         end

         DUMP_WAIT: begin
            // The word is shifted out MSB first; the top byte is always on the line.
            if (i_tx_done) begin
               tx_word_d = tx_word_q << NB_DATA;
               byte_d    = byte_q + 2'd1;
               if (byte_q != LAST_BYTE) begin
                  state_d = DUMP_TX;
               end else if (didx_q == LAST_IDX) begin
                  didx_d  = '0;
                  state_d = IDLE;
               end else begin
                  didx_d  = didx_q + IDX_W'(1);
                  state_d = DUMP_ADDR;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign o_tx_data        = tx_word_q[NB_REG-1 -: NB_DATA];
   assign o_tx_start       = tx_start;
   assign o_dunit_clk_en   = clk_en;
   assign o_dunit_reset_pc = reset_pc_q;
   assign o_dunit_w_mem    = w_mem;
   assign o_dunit_addr     = addr_q;
   assign o_dunit_data_if  = data_if_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
// tb_debug_unit : randomized self-checking bench for debug_unit.
// Revision      : 1.0  initial release
// ============================================================================
module tb_debug_unit;

   localparam int NB_REG      = 32;
   localparam int NB_DATA     = 8;
   localparam int N_REGS      = 32;
   localparam int N_MEM_WORDS = 32;
   localparam int DUMP_BYTES  = (N_REGS + N_MEM_WORDS) * 4;

   logic               i_clk;
   logic               i_reset;
   logic [NB_DATA-1:0] i_rx_data;
   logic               i_rx_done;
   logic               i_tx_done;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_dunit_clk_en;
   logic               o_dunit_reset_pc;
   logic               o_dunit_w_mem;
   logic [NB_REG-1:0]  o_dunit_addr;
   logic [NB_REG-1:0]  o_dunit_data_if;
   logic [NB_REG-1:0]  i_dunit_reg;
   logic [NB_REG-1:0]  i_dunit_mem_data;
   logic               i_halt;

   debug_unit #(
      .NB_REG      (NB_REG),
      .NB_DATA     (NB_DATA),
      .N_REGS      (N_REGS),
      .N_MEM_WORDS (N_MEM_WORDS)
   ) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_rx_data        (i_rx_data),
      .i_rx_done        (i_rx_done),
      .i_tx_done        (i_tx_done),
      .o_tx_data        (o_tx_data),
      .o_tx_start       (o_tx_start),
      .o_dunit_clk_en   (o_dunit_clk_en),
      .o_dunit_reset_pc (o_dunit_reset_pc),
      .o_dunit_w_mem    (o_dunit_w_mem),
      .o_dunit_addr     (o_dunit_addr),
      .o_dunit_data_if  (o_dunit_data_if),
      .i_dunit_reg      (i_dunit_reg),
      .i_dunit_mem_data (i_dunit_mem_data),
      .i_halt           (i_halt)
   );

   // Pipeline stand-in: register k reads 0x100+k, data memory is a random array.
   logic [31:0] mem_model [N_MEM_WORDS];
   assign i_dunit_reg      = 32'h100 + 32'(o_dunit_addr[4:0]);
   assign i_dunit_mem_data = mem_model[o_dunit_addr[6:2]];

   int          checks;
   int          errors;
   int          clk_en_cnt;
   int          reset_pc_cnt;
   int          tx_start_cnt;
   int          stab_err;
   bit          backpressure;
   logic [63:0] wq  [$];
   logic [7:0]  txq [$];
   logic [31:0] exp_words [$];
   logic [7:0]  rsp_byte;
   int          rsp_d;
   bit          rsp_abort;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Output monitor, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (!i_reset) begin
            if (o_dunit_clk_en)   clk_en_cnt++;
            if (o_dunit_reset_pc) reset_pc_cnt++;
            if (o_tx_start)       tx_start_cnt++;
            if (o_dunit_w_mem)    wq.push_back({o_dunit_addr, o_dunit_data_if});
         end
      end
   end

   // UART transmitter stand-in with random latency and occasional illegal early done.
   initial begin
      i_tx_done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (!i_reset && o_tx_start) begin
            rsp_byte = o_tx_data;
            txq.push_back(rsp_byte);
            if ($urandom_range(0, 3) == 0) i_tx_done = 1'b1;
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            rsp_d     = backpressure ? 100 : int'($urandom_range(0, 3));
            rsp_abort = 1'b0;
            for (int c = 0; c < rsp_d; c++) begin
               @(negedge i_clk);
               if (i_reset) begin
                  rsp_abort = 1'b1;
                  break;
               end
               if (o_tx_data !== rsp_byte || o_tx_start !== 1'b0) stab_err++;
            end
            if (!rsp_abort && !i_reset) begin
               i_tx_done = 1'b1;
               @(posedge i_clk);
               #1;
               i_tx_done = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick(1);
      i_rx_done = 1'b0;
      tick(int'($urandom_range(1, 3)));
   endtask

   task automatic clear_obs();
      clk_en_cnt   = 0;
      reset_pc_cnt = 0;
      tx_start_cnt = 0;
      wq.delete();
      txq.delete();
   endtask

   task automatic wait_tx(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while (txq.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      check(tag, 64'(txq.size() >= n), 64'd1);
   endtask

   // Load N words (0 encodes 256) and remember what the pipeline should receive.
   task automatic send_load(input logic [7:0] n);
      int words;
      logic [31:0] w;
      words = (n == 8'd0) ? 256 : int'(n);
      exp_words.delete();
      send_byte(8'h4C);
      send_byte(n);
      for (int k = 0; k < words; k++) begin
         w = $urandom;
         exp_words.push_back(w);
         for (int b = 3; b >= 0; b--) send_byte(8'(w >> (8 * b)));
      end
   endtask

   function automatic int load_mismatches();
      int m;
      m = 0;
      if (wq.size() != exp_words.size()) return wq.size() + exp_words.size() + 1;
      for (int k = 0; k < exp_words.size(); k++)
         if (wq[k] !== {32'(4 * k), exp_words[k]}) m++;
      return m;
   endfunction

   function automatic logic [7:0] exp_dump_byte(input int i);
      logic [31:0] w;
      w = (i / 4 < N_REGS) ? 32'h100 + 32'(i / 4) : mem_model[i / 4 - N_REGS];
      return 8'(w >> (8 * (3 - i % 4)));
   endfunction

   function automatic int dump_mismatches();
      int m;
      m = 0;
      for (int i = 0; i < DUMP_BYTES; i++) begin
         if (i >= txq.size()) m++;
         else if (txq[i] !== exp_dump_byte(i)) m++;
      end
      return m;
   endfunction

   function automatic logic [31:0] tx_word(input int i);
      if (txq.size() < i + 4) return 32'hxxxx_xxxx;
      return {txq[i], txq[i+1], txq[i+2], txq[i+3]};
   endfunction

   initial begin
      checks       = 0;
      errors       = 0;
      stab_err     = 0;
      backpressure = 1'b0;
      i_reset      = 1'b1;
      i_rx_data    = '0;
      i_rx_done    = 1'b0;
      i_halt       = 1'b0;
      for (int m = 0; m < N_MEM_WORDS; m++) mem_model[m] = $urandom;
      mem_model[0] = 32'hDEADBEEF;
      clear_obs();
      tick(3);

      check("rst_tx_data",  64'(o_tx_data),        64'd0);
      check("rst_tx_start", 64'(o_tx_start),       64'd0);
      check("rst_clk_en",   64'(o_dunit_clk_en),   64'd0);
      check("rst_reset_pc", 64'(o_dunit_reset_pc), 64'd0);
      check("rst_w_mem",    64'(o_dunit_w_mem),    64'd0);
      check("rst_addr",     64'(o_dunit_addr),     64'd0);
      check("rst_data_if",  64'(o_dunit_data_if),  64'd0);
      i_reset = 1'b0;
      tick(2);

      // Unknown command byte
      clear_obs();
      send_byte(8'h00);
      tick(20);
      check("unknown_activity", 64'(clk_en_cnt + reset_pc_cnt + tx_start_cnt + wq.size()), 64'd0);

      // Directed two-word load
      clear_obs();
      foreach (exp_words[i]) exp_words[i] = 32'h0;
      send_byte(8'h4C); send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      tick(5);
      check("load2_count",    64'(wq.size()), 64'd2);
      check("load2_word0",    (wq.size() > 0) ? wq[0] : 64'hx, 64'h00000000_20010005);
      check("load2_word1",    (wq.size() > 1) ? wq[1] : 64'hx, 64'h00000004_FC000000);
      check("load2_reset_pc", 64'(reset_pc_cnt), 64'd1);
      check("load2_no_tx",    64'(tx_start_cnt), 64'd0);

      // Random short loads; the word index restarts at 0 for each command
      for (int it = 0; it < 3; it++) begin
         clear_obs();
         send_load(8'($urandom_range(1, 6)));
         tick(5);
         check("loadr_words",    64'(load_mismatches()), 64'd0);
         check("loadr_reset_pc", 64'(reset_pc_cnt), 64'd1);
      end

      // Count byte 0 means 256 words
      clear_obs();
      send_load(8'h00);
      tick(5);
      check("load256_count",    64'(wq.size()), 64'd256);
      check("load256_words",    64'(load_mismatches()), 64'd0);
      check("load256_last_adr", (wq.size() == 256) ? 64'(wq[255][63:32]) : 64'hx, 64'h3FC);
      check("load256_reset_pc", 64'(reset_pc_cnt), 64'd1);

      // Reset PC command
      clear_obs();
      send_byte(8'h52);
      tick(5);
      check("rpc_pulses", 64'(reset_pc_cnt), 64'd1);
      check("rpc_other",  64'(clk_en_cnt + tx_start_cnt + wq.size()), 64'd0);

      // Step, with command bytes thrown at it mid-dump
      clear_obs();
      send_byte(8'h53);
      wait_tx(20, 2000, "step_tx20_timeout");
      send_byte(8'h53); send_byte(8'h43); send_byte(8'h4C); send_byte(8'h52);
      wait_tx(DUMP_BYTES, 6000, "step_dump_timeout");
      tick(20);
      check("step_clk_en",    64'(clk_en_cnt), 64'd1);
      check("step_tx_count",  64'(tx_start_cnt), 64'(DUMP_BYTES));
      check("step_dump",      64'(dump_mismatches()), 64'd0);
      check("step_bytes0_3",  64'(tx_word(0)), 64'h00000100);
      check("step_bytes124",  64'(tx_word(124)), 64'h0000011F);
      check("step_ignored",   64'(reset_pc_cnt + wq.size()), 64'd0);

      // Continuous run halted after 50 enabled cycles
      clear_obs();
      send_byte(8'h43);
      for (int c = 0; c < 1000 && clk_en_cnt < 50; c++) tick(1);
      i_halt = 1'b1;
      wait_tx(DUMP_BYTES, 6000, "run_dump_timeout");
      tick(20);
      check("run_clk_en",   64'(clk_en_cnt), 64'd50);
      check("run_dump",     64'(dump_mismatches()), 64'd0);
      check("run_mem0",     64'(tx_word(128)), 64'hDEADBEEF);

      // Run requested while already halted
      clear_obs();
      send_byte(8'h43);
      wait_tx(DUMP_BYTES, 6000, "halted_dump_timeout");
      tick(20);
      check("halted_clk_en", 64'(clk_en_cnt), 64'd0);
      check("halted_dump",   64'(dump_mismatches()), 64'd0);
      i_halt = 1'b0;

      // Reset in the middle of a dump
      clear_obs();
      send_byte(8'h53);
      wait_tx(10, 2000, "mid_tx10_timeout");
      i_reset = 1'b1;
      tick(1);
      check("mid_rst_ctrl", 64'({o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem}), 64'd0);
      check("mid_rst_addr", 64'(o_dunit_addr), 64'd0);
      check("mid_rst_data", 64'(o_dunit_data_if), 64'd0);
      tick(2);
      i_reset = 1'b0;
      clear_obs();
      tick(30);
      check("mid_no_resume", 64'(tx_start_cnt), 64'd0);
      send_byte(8'h52);
      tick(5);
      check("mid_rpc_pulse", 64'(reset_pc_cnt), 64'd1);
      check("mid_rpc_other", 64'(clk_en_cnt + tx_start_cnt + wq.size()), 64'd0);

      // Slow transmitter
      clear_obs();
      stab_err     = 0;
      backpressure = 1'b1;
      send_byte(8'h53);
      wait_tx(DUMP_BYTES, 40000, "bp_dump_timeout");
      tick(150);
      backpressure = 1'b0;
      check("bp_tx_count", 64'(tx_start_cnt), 64'(DUMP_BYTES));
      check("bp_dump",     64'(dump_mismatches()), 64'd0);
      check("bp_stable",   64'(stab_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
